// File: rtl/rom_arbiter.sv
// Two-port read arbiter sharing one ROM read port (registered address, fixed access latency).
// Define ROM_ARB_RR_EN for round-robin tie breaking; otherwise port 0 always wins a tie.
//
// state  | meaning
// S_IDLE | free; grants the next request
// S_WAIT | read in flight; counting down ROM latency, requests ignored
module rom_arbiter #(
  parameter int ROM_LAT        = 1,
  parameter int ROM_DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata,
  output logic        rerr,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic        busy
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_WAIT   = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(ROM_LAT - 1);

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_win;
  logic        r_err;
  logic        w_win;
  logic [15:0] w_addr;
  logic        w_range_err;

`ifdef ROM_ARB_RR_EN
  logic        r_last;

  // r_last resets to 1 so the first tie goes to port 0
  assign w_win = (req0 && req1) ? ~r_last : req1;
`else
  assign w_win = req1 & ~req0;
`endif

  assign w_addr      = w_win ? addr1 : addr0;
  assign w_range_err = (w_addr >> ROM_DEPTH_LOG2) != 16'h0000;
  assign busy        = (r_state == S_WAIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_win    <= 1'b0;
      r_err    <= 1'b0;
      rom_addr <= 16'h0000;
      rdata    <= 16'h0000;
      rerr     <= 1'b0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      rvalid0  <= 1'b0;
      rvalid1  <= 1'b0;
`ifdef ROM_ARB_RR_EN
      r_last   <= 1'b1;
`endif
    end else begin
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req0 || req1) begin
            r_state  <= S_WAIT;
            rom_addr <= w_addr;
            r_win    <= w_win;
            r_err    <= w_range_err;
            r_cnt    <= CNT_LOAD;
            ack0     <= ~w_win;
            ack1     <= w_win;
`ifdef ROM_ARB_RR_EN
            r_last   <= w_win;
`endif
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            // out-of-range reads still take full latency but return zero
            rdata   <= r_err ? 16'h0000 : rom_data;
            rerr    <= r_err;
            rvalid0 <= ~r_win;
            rvalid1 <= r_win;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: two instances (ROM_LAT 1 and 3), directed scenarios then random traffic,
// checked by a grant/latency model feeding a response scoreboard.
module tb_rom_arbiter;

  typedef struct {
    bit          port;
    logic [15:0] data;
    bit          err;
    int          due;
  } exp_t;

`ifdef ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       reset_s;
  logic [1:0]       req0_s, req1_s;
  logic [1:0][15:0] addr0_s, addr1_s;
  logic [1:0]       ack0_w, ack1_w, rvalid0_w, rvalid1_w, rerr_w, busy_w;
  logic [1:0][15:0] rdata_w, rom_addr_w, rom_data_w;

  int errors = 0;
  int checks = 0;

  function automatic logic [15:0] rom_fn(input logic [15:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    if (lo == 8'h05) return 16'hA5A5;
    return {~lo, lo ^ 8'h5A};
  endfunction

  task automatic chk(input int g, input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL dut%0d %s: got %0h expected %0h at %0t", g, nm, act, expv, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;

    assign rom_data_w[g] = rom_fn(rom_addr_w[g]);

    rom_arbiter #(.ROM_LAT(LAT), .ROM_DEPTH_LOG2(8)) u_dut (
      .clk      (clk),
      .reset    (reset_s[g]),
      .req0     (req0_s[g]),
      .req1     (req1_s[g]),
      .addr0    (addr0_s[g]),
      .addr1    (addr1_s[g]),
      .ack0     (ack0_w[g]),
      .ack1     (ack1_w[g]),
      .rvalid0  (rvalid0_w[g]),
      .rvalid1  (rvalid1_w[g]),
      .rdata    (rdata_w[g]),
      .rerr     (rerr_w[g]),
      .rom_addr (rom_addr_w[g]),
      .rom_data (rom_data_w[g]),
      .busy     (busy_w[g])
    );

    exp_t        q[$];
    int          n = 0;
    int          next_free = 0;
    bit          last = 1'b1;
    bit          exp_ack0, exp_ack1, exp_busy, rst_seen;
    logic [15:0] exp_rom_addr = 16'h0000;

    // Reference: the port is free from next_free on; a grant at edge n returns at edge n+LAT.
    initial forever begin
      bit          win;
      logic [15:0] a;
      bit          e;
      @(posedge clk);
      n++;
      exp_ack0 = 1'b0;
      exp_ack1 = 1'b0;
      rst_seen = 1'b0;
      if (reset_s[g]) begin
        q.delete();
        next_free    = n + 1;
        last         = 1'b1;
        exp_rom_addr = 16'h0000;
        rst_seen     = 1'b1;
      end else if (n >= next_free && (req0_s[g] || req1_s[g])) begin
        if (req0_s[g] && req1_s[g]) win = RR ? (last == 1'b0) : 1'b0;
        else                        win = req1_s[g];
        a = win ? addr1_s[g] : addr0_s[g];
        e = (a > 16'h00FF);
        q.push_back('{port: win, data: (e ? 16'h0000 : rom_fn(a)), err: e, due: n + LAT});
        exp_rom_addr = a;
        next_free    = n + LAT + 1;
        last         = win;
        if (win) exp_ack1 = 1'b1; else exp_ack0 = 1'b1;
      end
      exp_busy = (n + 1 < next_free);
    end

    logic [15:0] hold_data = 16'h0000;
    bit          hold_err  = 1'b0;

    initial forever begin
      exp_t e;
      @(negedge clk);
      chk(g, "ack0", ack0_w[g], exp_ack0);
      chk(g, "ack1", ack1_w[g], exp_ack1);
      chk(g, "busy", busy_w[g], exp_busy);
      chk(g, "rom_addr", rom_addr_w[g], exp_rom_addr);
      if (rst_seen) begin
        hold_data = 16'h0000;
        hold_err  = 1'b0;
      end
      if (rvalid0_w[g] || rvalid1_w[g]) begin
        chk(g, "rvalid_onehot", rvalid0_w[g] & rvalid1_w[g], 0);
        if (q.size() == 0) begin
          chk(g, "rvalid_unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          chk(g, "rv_port", rvalid1_w[g], e.port);
          chk(g, "rv_time", n, e.due);
          hold_data = e.data;
          hold_err  = e.err;
        end
      end else if (q.size() > 0 && q[0].due <= n) begin
        chk(g, "rvalid_missing", 0, 1);
        void'(q.pop_front());
      end
      chk(g, "rdata", rdata_w[g], hold_data);
      chk(g, "rerr", rerr_w[g], hold_err);
    end
  end

  task automatic set_req(input int g, input int p, input bit v, input logic [15:0] a);
    if (p == 0) begin req0_s[g] = v; addr0_s[g] = a; end
    else        begin req1_s[g] = v; addr1_s[g] = a; end
  endtask

  function automatic bit ack_of(input int g, input int p);
    return (p == 0) ? ack0_w[g] : ack1_w[g];
  endfunction

  function automatic bit req_of(input int g, input int p);
    return (p == 0) ? req0_s[g] : req1_s[g];
  endfunction

  function automatic bit rv_of(input int g, input int p);
    return (p == 0) ? rvalid0_w[g] : rvalid1_w[g];
  endfunction

  task automatic wait_ack(input int g, input int p);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack_of(g, p)) begin got = 1'b1; break; end
    end
    chk(g, "ack_wait", got, 1);
  endtask

  task automatic wait_rvalid(input int g, input int p);
    bit got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rv_of(g, p)) begin got = 1'b1; break; end
    end
    chk(g, "rvalid_wait", got, 1);
  endtask

  task automatic txn(input int g, input int p, input logic [15:0] a);
    set_req(g, p, 1'b1, a);
    wait_ack(g, p);
    set_req(g, p, 1'b0, 16'h0000);
  endtask

  function automatic logic [15:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return 16'h0005;
      1:       return 16'h00FF;
      2:       return 16'($urandom_range(256, 65535));
      default: return 16'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt0, cnt1;
    reset_s = 2'b11;
    req0_s  = 2'b00;
    req1_s  = 2'b00;
    addr0_s = '0;
    addr1_s = '0;
    repeat (3) @(negedge clk);
    reset_s = 2'b00;

    // single fetch, known word
    txn(0, 0, 16'h0005);
    wait_rvalid(0, 0);
    chk(0, "t1_rdata", rdata_w[0], 16'hA5A5);
    chk(0, "t1_rerr", rerr_w[0], 0);
    repeat (2) @(negedge clk);

    // both ports requesting continuously
    set_req(0, 0, 1'b1, 16'h0010);
    set_req(0, 1, 1'b1, 16'h0020);
    cnt0 = 0;
    cnt1 = 0;
    repeat (12) begin
      @(negedge clk);
      cnt0 += int'(ack0_w[0]);
      cnt1 += int'(ack1_w[0]);
    end
    set_req(0, 0, 1'b0, 16'h0000);
    set_req(0, 1, 1'b0, 16'h0000);
    chk(0, "tie_grants0", cnt0, RR ? 3 : 6);
    chk(0, "tie_grants1", cnt1, RR ? 3 : 0);
    repeat (4) @(negedge clk);

    // out-of-range read
    txn(0, 1, 16'h0100);
    wait_rvalid(0, 1);
    chk(0, "oor_rdata", rdata_w[0], 16'h0000);
    chk(0, "oor_rerr", rerr_w[0], 1);
    repeat (2) @(negedge clk);

    // latency 3, second port raised during the read
    set_req(1, 0, 1'b1, 16'h00FF);
    wait_ack(1, 0);
    set_req(1, 0, 1'b0, 16'h0000);
    set_req(1, 1, 1'b1, 16'h0042);
    wait_rvalid(1, 0);
    chk(1, "lat3_rdata", rdata_w[1], rom_fn(16'h00FF));
    @(negedge clk);
    chk(1, "lat3_ack1_after", ack1_w[1], 1);
    set_req(1, 1, 1'b0, 16'h0000);
    wait_rvalid(1, 1);
    repeat (2) @(negedge clk);

    // reset one cycle after the grant drops the read
    for (int g = 0; g < 2; g++) begin
      set_req(g, 0, 1'b1, 16'h0033);
      wait_ack(g, 0);
      set_req(g, 0, 1'b0, 16'h0000);
      reset_s[g] = 1'b1;
      @(negedge clk);
      reset_s[g] = 1'b0;
      repeat (5) @(negedge clk);
      txn(g, 0, 16'h0044);
      wait_rvalid(g, 0);
      chk(g, "post_reset_rdata", rdata_w[g], rom_fn(16'h0044));
      repeat (2) @(negedge clk);
    end

    // back-to-back request in the rvalid cycle
    txn(0, 0, 16'h0011);
    wait_rvalid(0, 0);
    set_req(0, 0, 1'b1, 16'h0022);
    @(negedge clk);
    chk(0, "b2b_ack", ack0_w[0], 1);
    set_req(0, 0, 1'b0, 16'h0000);
    wait_rvalid(0, 0);
    chk(0, "b2b_rdata", rdata_w[0], rom_fn(16'h0022));
    repeat (2) @(negedge clk);

    // random traffic on both instances
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        reset_s[g] = ($urandom_range(0, 299) == 0);
        for (int p = 0; p < 2; p++) begin
          if (ack_of(g, p)) begin
            if ($urandom_range(0, 3) == 0) set_req(g, p, 1'b1, rand_addr());
            else                           set_req(g, p, 1'b0, 16'h0000);
          end else if (!req_of(g, p) && $urandom_range(0, 2) == 0) begin
            set_req(g, p, 1'b1, rand_addr());
          end
        end
      end
    end
    @(negedge clk);
    reset_s = 2'b00;
    req0_s  = 2'b00;
    req1_s  = 2'b00;
    repeat (10) @(negedge clk);
    chk(0, "drain", g_dut[0].q.size(), 0);
    chk(1, "drain", g_dut[1].q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
